// File: rtl/rv_pkg.sv
// Shared front-end types: the {pc, instr} pair carried through the prefetch queue.
package rv_pkg;
   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Power-of-2 synchronous FIFO with flush; head is read combinationally (no bypass).
module sync_fifo
   import rv_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  T                       din,
   output T                       dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   T           mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic        do_pop;

   // Extra pointer bit distinguishes full from empty; the difference is the fill level.
   assign count  = wptr - rptr;
   assign do_pop = pop && (count != '0);
   assign dout   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push)   wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst && !flush) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, one-deep in-flight tracking against a 1-cycle imem, and a prefetch queue.
module fetch_unit
   import rv_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
)(
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req,
   output logic [WIDTH-1:0]       imem_addr,
   input  logic [WIDTH-1:0]       imem_rdata,
   input  logic                   redirect,
   input  logic [WIDTH-1:0]       redirect_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [WIDTH-1:0]       instr,
   output logic [WIDTH-1:0]       instr_pc,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int             CW     = $clog2(DEPTH) + 1;
   localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } entry_t;

   logic [WIDTH-1:0] fetch_pc, inflight_pc_q;
   logic             inflight_q, push, pop, unused_lsb;
   logic [CW-1:0]    count;
   logic [CW:0]      pending;
   entry_t           wr, head;

   // Credit counts queued plus in-flight entries, so a response can always be absorbed.
   assign pending    = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign imem_req   = !rst && !redirect && (pending < DEPTH_C);
   assign imem_addr  = fetch_pc;
   assign unused_lsb = ^redirect_pc[1:0];

   assign push        = inflight_q && !redirect;
   assign pop         = instr_valid && instr_ready;
   assign wr          = '{pc: inflight_pc_q, instr: imem_rdata};
   assign instr_valid = (count != '0);
   assign instr       = head.instr;
   assign instr_pc    = head.pc;
   assign occupancy   = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc      <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
      end else if (redirect) begin
         fetch_pc   <= {redirect_pc[WIDTH-1:2], 2'b00};
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= imem_req;
         if (imem_req) begin
            fetch_pc      <= fetch_pc + WIDTH'(INSTR_BYTES);
            inflight_pc_q <= fetch_pc;
         end
      end
   end

   sync_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   (wr),
      .dout  (head),
      .count (count)
   );
endmodule
